gcd_scheduler: RTL and testbench

Shares one subtractive GCD engine among NREQ requesters. Each requester presents an operand pair with a valid/ready handshake. A round-robin arbiter picks one requester and the engine computes the result. The result comes back on a single response channel, tagged with the requester index. The block sits between the requesting control logic and the GCD datapath, which is a sub-module.

---
 rtl/gcd_pkg.sv | 33 +++
 rtl/gcd_core.sv | 68 ++++++
 rtl/gcd_scheduler.sv | 92 +++++++++
 tb/tb_gcd_scheduler.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared types and helpers for the GCD scheduler: FSM encoding, default width,
// and the round-robin grant search.
package gcd_pkg;

   localparam int DEF_WIDTH = 4;
   localparam int MAX_NREQ  = 8;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      RESP = 2'b10
   } state_t;

   // First set bit of valid starting at ptr and wrapping modulo n (n <= MAX_NREQ).
   function automatic logic [2:0] rr_pick(input logic [7:0] valid,
                                          input logic [2:0] ptr,
                                          input int         n);
      logic [2:0] pick;
      logic       found;
      int         idx;
      pick  = '0;
      found = 1'b0;
      for (int k = 0; k < MAX_NREQ; k++) begin
         idx = (int'(ptr) + k) % n;
         if (k < n && !found && valid[idx[2:0]]) begin
            pick  = idx[2:0];
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/gcd_core.sv
// Subtractive GCD engine: one subtraction or zero-check per cycle while busy.
// done pulses in the zero-check cycle; result is registered on that edge and held.
module gcd_core
   import gcd_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             busy_q, busy_d;

   always_comb begin
      x_d      = x_q;
      y_d      = y_q;
      result_d = result_q;
      busy_d   = busy_q;
      done     = 1'b0;
      if (start) begin
         x_d    = a;
         y_d    = b;
         busy_d = 1'b1;
      end else if (busy_q) begin
         // Zero checks take priority so gcd(0,0)=0 and gcd(0,b)=b fall out naturally.
         if (x_q == '0) begin
            result_d = y_q;
            busy_d   = 1'b0;
            done     = 1'b1;
         end else if (y_q == '0) begin
            result_d = x_q;
            busy_d   = 1'b0;
            done     = 1'b1;
         end else if (x_q >= y_q) begin
            x_d = x_q - y_q;
         end else begin
            y_d = y_q - x_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x_q      <= '0;
         y_q      <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
      end else begin
         x_q      <= x_d;
         y_q      <= y_d;
         result_q <= result_d;
         busy_q   <= busy_d;
      end
   end

   assign busy   = busy_q;
   assign result = result_q;

endmodule

// File: rtl/gcd_scheduler.sv
// Round-robin front end sharing one gcd_core among NREQ requesters; results
// return on a single channel tagged with the owning requester index.
module gcd_scheduler
   import gcd_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = DEF_WIDTH,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic [NREQ-1:0]       req_ready,
   output logic                  rsp_valid,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_gcd,
   input  logic                  rsp_ready
);

   state_t           state_q, state_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [7:0]       valid_ext;
   logic [IDW-1:0]   grant;
   logic             any_valid;
   logic             accept;
   logic             core_busy;
   logic             core_done;
   logic [WIDTH-1:0] core_result;

   always_comb begin
      valid_ext             = '0;
      valid_ext[NREQ-1:0]   = req_valid;
   end

   assign grant     = IDW'(rr_pick(valid_ext, 3'(ptr_q), NREQ));
   assign any_valid = |req_valid;
   // The busy interlock keeps a stale engine from being restarted under a new id.
   assign accept    = (state_q == IDLE) && any_valid && !core_busy;

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = accept && (grant == IDW'(gi));
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               id_d    = grant;
               ptr_d   = (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
               state_d = RUN;
            end
         end
         RUN:     if (core_done) state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
      end
   end

   gcd_core #(.WIDTH(WIDTH)) u_core (
      .clk    (clk),
      .reset  (reset),
      .start  (accept),
      .a      (req_a[grant*WIDTH +: WIDTH]),
      .b      (req_b[grant*WIDTH +: WIDTH]),
      .busy   (core_busy),
      .done   (core_done),
      .result (core_result)
   );

   assign rsp_valid = (state_q == RESP);
   assign rsp_id    = id_q;
   assign rsp_gcd   = core_result;

endmodule

// File: tb/tb_gcd_scheduler.sv
// Directed bench for gcd_scheduler (NREQ=4, WIDTH=4) with hand-computed results.
module tb_gcd_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [3:0]  rsp_gcd;
   logic        rsp_ready;

   int tests_run    = 0;
   int tests_failed = 0;

   gcd_scheduler dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_gcd   (rsp_gcd),
      .rsp_ready (rsp_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full transaction: grant check, S subtraction cycles, response, optional stall.
   task automatic run_one(input int id, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] g, input int s, input bit hold, input int stall);
      rsp_ready          = (stall == 0);
      req_valid[id]      = 1'b1;
      req_a[id*4 +: 4]   = a;
      req_b[id*4 +: 4]   = b;
      #1;
      check($sformatf("grant%0d_ready", id), 32'(req_ready), 32'(1 << id));
      step();
      if (!hold) req_valid = '0;
      check("run_ready_low", 32'(req_ready), 32'd0);
      repeat (s) step();
      check("pre_rsp_valid", 32'(rsp_valid), 32'd0);
      step();
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_id", 32'(rsp_id), 32'(id));
      check($sformatf("gcd(%0d,%0d)", a, b), 32'(rsp_gcd), 32'(g));
      for (int i = 0; i < stall; i++) begin
         step();
         check("stall_valid", 32'(rsp_valid), 32'd1);
         check("stall_gcd", 32'(rsp_gcd), 32'(g));
         check("stall_id", 32'(rsp_id), 32'(id));
      end
      rsp_ready = 1'b1;
      step();
      check("post_rsp_valid", 32'(rsp_valid), 32'd0);
      check("post_state_idle", 32'(dut.state_q), 32'd0);
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      step();
      step();
      reset = 1'b0;
      check("reset_ready", 32'(req_ready), 32'd0);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_rsp_id", 32'(rsp_id), 32'd0);
      check("reset_rsp_gcd", 32'(rsp_gcd), 32'd0);
      check("reset_ptr", 32'(dut.ptr_q), 32'd0);

      // Single request from requester 2: (4,6) needs 3 subtractions.
      run_one(2, 4'd4, 4'd6, 4'd2, 3, 1'b0, 0);

      // Zero operands finish on the first zero-check.
      run_one(3, 4'd0, 4'd9, 4'd9, 0, 1'b0, 0);
      run_one(0, 4'd9, 4'd0, 4'd9, 0, 1'b0, 0);
      run_one(1, 4'd0, 4'd0, 4'd0, 0, 1'b0, 0);

      // Fairness from a fresh pointer: all valid with (12,8), S=3, gcd 4.
      reset = 1'b1;
      step();
      reset = 1'b0;
      req_a = {4{4'd12}};
      req_b = {4{4'd8}};
      req_valid = 4'b1111;
      run_one(0, 4'd12, 4'd8, 4'd4, 3, 1'b1, 0);
      run_one(1, 4'd12, 4'd8, 4'd4, 3, 1'b1, 0);
      run_one(2, 4'd12, 4'd8, 4'd4, 3, 1'b1, 0);
      run_one(3, 4'd12, 4'd8, 4'd4, 3, 1'b1, 0);
      run_one(0, 4'd12, 4'd8, 4'd4, 3, 1'b0, 0);

      // Worst case (15,1) on requester 1 with 5 cycles of backpressure.
      run_one(1, 4'd15, 4'd1, 4'd1, 15, 1'b0, 5);

      // Reset in the middle of a (15,1) run on requester 2.
      req_valid[2]   = 1'b1;
      req_a[8 +: 4]  = 4'd15;
      req_b[8 +: 4]  = 4'd1;
      #1;
      check("mid_grant2_ready", 32'(req_ready), 32'b0100);
      step();
      req_valid = '0;
      repeat (5) step();
      check("mid_busy", 32'(dut.state_q), 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mid_reset_state", 32'(dut.state_q), 32'd0);
      check("mid_reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("mid_reset_ptr", 32'(dut.ptr_q), 32'd0);
      run_one(0, 4'd5, 4'd5, 4'd5, 1, 1'b0, 0);

      // Requester 1 withdraws before any edge: never granted, nothing returned.
      req_valid[1] = 1'b1;
      req_a[4 +: 4] = 4'd6;
      req_b[4 +: 4] = 4'd3;
      #1;
      check("withdraw_ready_seen", 32'(req_ready), 32'b0010);
      req_valid = '0;
      #1;
      check("withdraw_ready_drop", 32'(req_ready), 32'd0);
      for (int i = 0; i < 6; i++) begin
         step();
         check("withdraw_no_rsp", 32'(rsp_valid), 32'd0);
         check("withdraw_idle", 32'(dut.state_q), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
